// File: rtl/aes_enc_round_ctrl.sv
// aes_enc_round_ctrl
//   Iterative AES encryption sequencer. Takes one 128-bit plaintext block and
//   walks it through whitening, NR-1 full rounds and a final round without
//   mix_columns. Round keys are fetched one per round from the key-schedule
//   block over a request/valid handshake. The ciphertext is returned over
//   valid/ready. Only one block is in flight at a time.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     plaintext handshake, in_block = plaintext
//   rk_req/rk_idx         round-key request and index (0..NR)
//   rk_valid/rk_data      round key for rk_idx, sampled only when rk_valid
//   out_valid/out_ready   ciphertext handshake, out_block = ciphertext
//   busy                  high whenever the sequencer is not idle
//   round                 current round index (status)
//
// Byte order everywhere: byte 0 in [127:120] ... byte 15 in [7:0];
// byte 4c+r is row r, column c of the AES state.
module aes_enc_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [3:0]   round
);

  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [127:0] state_p0;
  logic [3:0]   round_p0;
  logic [127:0] out_p0;
  logic [127:0] sr_p0;
  logic [127:0] full_rnd;
  logic [127:0] last_rnd;

  // ---------------------------------------------------------------
  // GF(2^8) helpers and AES round primitives
  // ---------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------
  // Round datapath (combinational from state_p0 and rk_data)
  // ---------------------------------------------------------------
  assign sr_p0    = shift_rows(sub_bytes(state_p0));
  assign full_rnd = mix_columns(sr_p0) ^ rk_data;
  assign last_rnd = sr_p0 ^ rk_data;

  // ---------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  // ---------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------
  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE:    if (in_valid) fsm_nxt = RUN;
      RUN:     if (rk_valid && (round_p0 == LAST)) fsm_nxt = DONE;
      DONE:    if (out_ready) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------
  always_comb begin
    in_ready  = (fsm == IDLE);
    rk_req    = (fsm == RUN);
    out_valid = (fsm == DONE);
    busy      = (fsm != IDLE);
  end

  assign rk_idx    = round_p0;
  assign round     = round_p0;
  assign out_block = out_p0;

  // ---------------------------------------------------------------
  // State / round / ciphertext registers
  // out_p0 is loaded only when the last round completes, so it keeps the
  // previous ciphertext while the next block is being processed.
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= '0;
      round_p0 <= '0;
      out_p0   <= '0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_p0 <= in_block;
            round_p0 <= '0;
          end
        end
        RUN: begin
          if (rk_valid) begin
            if (round_p0 == 4'd0) begin
              state_p0 <= state_p0 ^ rk_data;
            end else if (round_p0 == LAST) begin
              state_p0 <= last_rnd;
              out_p0   <= last_rnd;
            end else begin
              state_p0 <= full_rnd;
            end
            // the counter parks at NR until the result is consumed
            if (round_p0 != LAST) round_p0 <= round_p0 + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) round_p0 <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
module tb_aes_enc_round_ctrl;

  localparam int NR10 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, rk_req, rk_valid, out_valid, out_ready, busy;
  logic [127:0] in_block, rk_data, out_block;
  logic [3:0]   rk_idx, round;

  logic         in14_valid, in14_ready, rk14_req, rk14_valid, out14_valid, out14_ready, busy14;
  logic [127:0] in14_block, rk14_data, out14_block;
  logic [3:0]   rk14_idx, round14;

  aes_enc_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .busy(busy), .round(round)
  );

  aes_enc_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in14_valid), .in_ready(in14_ready), .in_block(in14_block),
    .rk_req(rk14_req), .rk_idx(rk14_idx), .rk_valid(rk14_valid), .rk_data(rk14_data),
    .out_valid(out14_valid), .out_ready(out14_ready), .out_block(out14_block),
    .busy(busy14), .round(round14)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   expt [0:255];
  logic [7:0]   logt [0:255];
  logic [7:0]   sb   [0:255];
  logic [31:0]  w    [0:59];
  logic [127:0] rk10 [0:15];
  logic [127:0] rk14 [0:15];

  function automatic logic [7:0] m_xt(input logic [7:0] b);
    logic [7:0] sh;
    sh = {b[6:0], 1'b0};
    return b[7] ? (sh ^ 8'h1b) : sh;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return expt[(int'(logt[a]) + int'(logt[b])) % 255];
  endfunction

  // S-box from log/antilog tables (generator 3) plus the affine map.
  task automatic build_tables();
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 256; i++) logt[i] = 8'h00;
    for (int i = 0; i < 255; i++) begin
      expt[i] = p;
      logt[p] = 8'(i);
      p = p ^ m_xt(p);
    end
    expt[255] = expt[0];
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s, cst;
      cst = 8'h63;
      inv = (x == 0) ? 8'h00 : expt[(255 - int'(logt[x])) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ cst[b];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = m_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  task automatic load10();
    for (int r = 0; r <= NR10; r++) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load14();
    for (int r = 0; r <= 14; r++) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk10[0][127-8*i -: 8];
    for (int r = 1; r <= NR10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < NR10) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) a[row] = s[4*c+row];
          for (int row = 0; row < 4; row++)
            s[4*c+row] = gmul(8'h02, a[row]) ^ gmul(8'h03, a[(row+1)%4]) ^ a[(row+2)%4] ^ a[(row+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk10[r][127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- key server / output-ready driver ----------------
  int gap_pct   = 0;
  int ordy_mode = 1;  // 0 low, 1 high, 2 random
  bit spurious  = 0;

  initial begin
    rk_valid    = 1'b0;
    rk_data     = '0;
    out_ready   = 1'b1;
    rk14_valid  = 1'b0;
    rk14_data   = '0;
    out14_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (ordy_mode == 2) ? ($urandom_range(0, 1) == 1) : (ordy_mode == 1);
      if (rk_req) begin
        rk_valid = ($urandom_range(0, 99) >= gap_pct);
        rk_data  = rk_valid ? rk10[rk_idx] : {$urandom, $urandom, $urandom, $urandom};
      end else begin
        rk_valid = spurious;
        rk_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      rk14_valid = rk14_req;
      rk14_data  = rk14_req ? rk14[rk14_idx] : {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [127:0] exp_q[$];
  int           cyc = 0;
  int           exp_idx = 0, gaps = 0, acc_cyc = 0, last_ohs = -100, b2b_gap = 0;
  bit           prev_ov = 0, prev_hs = 0;
  logic [127:0] prev_blk = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_idx = 0;
      gaps    = 0;
      prev_ov = 0;
      prev_hs = 0;
    end else begin
      if (rk_req) begin
        chk(rk_idx == 4'(exp_idx), "rk_idx", 128'(rk_idx), 128'(exp_idx));
        if (rk_valid) exp_idx++;
        else          gaps++;
      end
      if (out_valid && !prev_ov) begin
        chk(cyc - acc_cyc == NR10 + 2 + gaps, "latency", 128'(cyc - acc_cyc), 128'(NR10 + 2 + gaps));
        chk(exp_idx == NR10 + 1, "keys_fetched", 128'(exp_idx), 128'(NR10 + 1));
      end
      if (out_valid && prev_ov && !prev_hs)
        chk(out_block == prev_blk, "out_stable", out_block, prev_blk);
      if (out_valid && out_ready) begin
        bit have;
        have = (exp_q.size() != 0);
        chk(have, "out_expected", 128'(exp_q.size()), 128'd1);
        if (have) begin
          logic [127:0] e;
          e = exp_q.pop_front();
          chk(out_block == e, "ciphertext", out_block, e);
        end
        last_ohs = cyc;
      end
      if (in_valid && in_ready) begin
        acc_cyc = cyc;
        b2b_gap = cyc - last_ohs;
        exp_idx = 0;
        gaps    = 0;
      end
      prev_ov  = out_valid;
      prev_hs  = out_valid && out_ready;
      prev_blk = out_block;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send(input logic [127:0] blk, input logic [127:0] expv, input bit keep);
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    in_block = blk;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        ok = 1;
        break;
      end
    end
    chk(ok, "accept_timeout", 128'(ok), 128'd1);
    if (ok) exp_q.push_back(expv);
    @(posedge clk); #1;
    if (!keep) begin
      in_valid = 1'b0;
      in_block = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    chk(ok, "idle_timeout", 128'(ok), 128'd1);
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, b, k;
    bit           ok;
    int           n;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_block   = '0;
    in14_valid = 1'b0;
    in14_block = '0;
    build_tables();
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    load14();
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    load10();

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(in_ready == 1'b1, "rst_in_ready", 128'(in_ready), 128'd1);
    chk(rk_req == 1'b0 && out_valid == 1'b0 && busy == 1'b0, "rst_ctrl",
        128'({rk_req, out_valid, busy}), 128'd0);
    chk(rk_idx == 4'd0 && round == 4'd0, "rst_round", 128'({rk_idx, round}), 128'd0);
    chk(out_block == '0, "rst_out_block", out_block, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // FIPS-197 App. B, keys always available
    gap_pct   = 0;
    ordy_mode = 1;
    send(PT_B, CT_B, 1'b0);
    wait_idle();

    // App. C.1 with key gaps, consumer stalled, spurious keys while DONE
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    load10();
    gap_pct   = 30;
    ordy_mode = 0;
    send(PT_C, CT_C1, 1'b0);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    chk(ok, "c1_out_timeout", 128'(ok), 128'd1);
    spurious = 1;
    repeat (5) begin
      @(negedge clk);
      chk(out_valid && out_block == CT_C1, "c1_hold", out_block, CT_C1);
    end
    spurious  = 0;
    ordy_mode = 1;
    wait_idle();

    // spurious keys while IDLE
    spurious = 1;
    repeat (4) begin
      @(negedge clk);
      chk(out_block == CT_C1, "idle_spurious_blk", out_block, CT_C1);
      chk(!busy && round == 4'd0, "idle_spurious_ctrl", 128'({busy, round}), 128'd0);
    end
    spurious = 0;
    @(posedge clk); #1;

    // back-to-back with in_valid held high
    gap_pct = 0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    send(a, model_enc(a), 1'b1);
    send(b, model_enc(b), 1'b0);
    wait_idle();
    chk(b2b_gap == 1, "b2b_accept_gap", 128'(b2b_gap), 128'd1);

    // random key, random gaps, random consumer
    k = {$urandom, $urandom, $urandom, $urandom};
    expand({k, 128'h0}, 4, 10);
    load10();
    gap_pct   = int'($urandom_range(0, 50));
    ordy_mode = 2;
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      send(a, model_enc(a), 1'b0);
    end
    wait_idle();
    ordy_mode = 1;

    // reset in the middle of round 5
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    load10();
    gap_pct = 0;
    @(posedge clk); #1;
    send(PT_B, CT_B, 1'b0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (round == 4'd4) begin
        ok = 1;
        break;
      end
    end
    chk(ok, "round4_timeout", 128'(ok), 128'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(!busy && in_ready && !rk_req && !out_valid, "midrun_rst_ctrl",
        128'({busy, in_ready, rk_req, out_valid}), 128'b0100);
    chk(round == 4'd0 && out_block == '0, "midrun_rst_data", out_block, 128'd0);
    @(posedge clk); #1;
    send(PT_B, CT_B, 1'b0);
    wait_idle();

    // reset wins over an input handshake
    in_valid = 1'b1;
    in_block = PT_B;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk(!busy && round == 4'd0, "rst_vs_accept", 128'({busy, round}), 128'd0);
    @(posedge clk); #1;

    // AES-256, NR=14
    in14_valid = 1'b1;
    in14_block = PT_C;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in14_ready) begin
        ok = 1;
        break;
      end
    end
    chk(ok, "aes256_accept", 128'(ok), 128'd1);
    @(posedge clk); #1;
    in14_valid = 1'b0;
    in14_block = {$urandom, $urandom, $urandom, $urandom};
    n  = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rk14_req && rk14_valid) begin
        chk(rk14_idx == 4'(n), "rk14_idx", 128'(rk14_idx), 128'(n));
        n++;
      end
      if (out14_valid) begin
        ok = 1;
        break;
      end
    end
    chk(ok, "aes256_out_timeout", 128'(ok), 128'd1);
    chk(n == 15, "rk14_count", 128'(n), 128'd15);
    chk(out14_block == CT_C3, "aes256_ct", out14_block, CT_C3);

    repeat (3) @(negedge clk);
    chk(exp_q.size() == 0 && !busy14, "drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
